// File: rtl/irq_prio_dispatcher_if.sv
// Signal bundle between the AXI-lite register file / interrupt sources (master)
// and the priority interrupt dispatcher (slave).
interface irq_prio_dispatcher_if #(
   parameter int NUM_IRQ = 8,
   parameter int IDW     = 3
);
   logic [NUM_IRQ-1:0]     irq_in;
   logic [NUM_IRQ-1:0]     mask;
   logic [NUM_IRQ*IDW-1:0] prio_table;
   logic                   glob_en;
   // ack is a one-cycle pulse. It is accepted only while irq_out is high.
   // Any ack seen while irq_out is low produces a one-cycle ack_err and is otherwise ignored.
   logic                   ack;
   logic                   irq_out;
   logic [IDW-1:0]         irq_id;
   logic [NUM_IRQ-1:0]     pending;
   logic                   ack_err;
   logic [1:0]             dbg_state;

   modport master (
      output irq_in, mask, prio_table, glob_en, ack,
      input  irq_out, irq_id, pending, ack_err, dbg_state
   );

   modport slave (
      input  irq_in, mask, prio_table, glob_en, ack,
      output irq_out, irq_id, pending, ack_err, dbg_state
   );
endinterface

// File: rtl/irq_prio_dispatcher.sv
// Priority interrupt dispatcher: latches rising edges and dispatches the highest-priority
// eligible source from a programmable slot table. Each dispatch holds until it is acknowledged.
module irq_prio_dispatcher #(
   parameter int NUM_IRQ = 8,
   parameter int IDW     = 3
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   irq_prio_dispatcher_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARB    = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [NUM_IRQ-1:0] irq_q, pending_r, elig, rise, clr_vec;
   logic               irq_out_r, irq_out_nxt;
   logic               ack_err_r, ack_err_nxt;
   logic [IDW-1:0]     irq_id_r, irq_id_nxt;
   logic               sel_found;
   logic [IDW-1:0]     sel_id;

   assign rise = bus.irq_in & ~irq_q;
   assign elig = pending_r & bus.mask;

   // Lowest slot listing an eligible, in-range source wins, so later duplicates never matter.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         if (!sel_found && (int'(bus.prio_table[k*IDW +: IDW]) < NUM_IRQ)
             && elig[bus.prio_table[k*IDW +: IDW]]) begin
            sel_found = 1'b1;
            sel_id    = bus.prio_table[k*IDW +: IDW];
         end
      end
   end

   always_comb begin
      clr_vec = '0;
      if (state == ACTIVE && bus.ack) begin
         clr_vec[irq_id_r] = 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      irq_out_nxt = irq_out_r;
      irq_id_nxt  = irq_id_r;
      ack_err_nxt = bus.ack && (state != ACTIVE);
      case (state)
         IDLE: begin
            if (bus.glob_en && (elig != '0)) begin
               state_nxt = ARB;
            end
         end
         ARB: begin
            if (bus.glob_en && sel_found) begin
               state_nxt   = ACTIVE;
               irq_out_nxt = 1'b1;
               irq_id_nxt  = sel_id;
            end else begin
               state_nxt = IDLE;
            end
         end
         ACTIVE: begin
            if (bus.ack) begin
               state_nxt   = IDLE;
               irq_out_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt   = IDLE;
            irq_out_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         irq_q     <= '0;
         pending_r <= '0;
         irq_out_r <= 1'b0;
         irq_id_r  <= '0;
         ack_err_r <= 1'b0;
      end else begin
         state     <= state_nxt;
         irq_q     <= bus.irq_in;
         // A new edge in the same cycle as the clearing ack keeps the bit set.
         pending_r <= (pending_r & ~clr_vec) | rise;
         irq_out_r <= irq_out_nxt;
         irq_id_r  <= irq_id_nxt;
         ack_err_r <= ack_err_nxt;
      end
   end

   assign bus.irq_out   = irq_out_r;
   assign bus.irq_id    = irq_id_r;
   assign bus.pending   = pending_r;
   assign bus.ack_err   = ack_err_r;
   assign bus.dbg_state = state;

endmodule

// File: doc/irq_prio_dispatcher.md
# irq_prio_dispatcher

Priority interrupt dispatcher for the AXI-lite interrupt controller.
- Captures rising edges on up to NUM_IRQ interrupt sources and applies a per-source enable mask and a global enable.
- Picks the highest-priority pending source from a software-programmed priority table and raises a single interrupt line towards the processor with that source's ID.
- Holds that interrupt until software acknowledges it through the register front-end, then dispatches the next one.
- Sits between the AXI-lite register file (mask, priority table, control/status, ack) and the CPU interrupt input.

## Interface
- NUM_IRQ, 8, number of interrupt sources and number of priority-table slots
- IDW, 3, source-ID width; NUM_IRQ <= 2**IDW
- aclk  in  1  system clock, all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- irq_in  in  NUM_IRQ  raw interrupt request levels, already synchronous to aclk
- mask  in  NUM_IRQ  per-source enable; bit i = 1 enables source i
- prio_table  in  NUM_IRQ*IDW  slot k = prio_table[k*IDW +: IDW] holds a source ID; slot 0 is highest priority
- glob_en  in  1  global dispatch enable (control register bit)
- ack  in  1  single-cycle pulse: software acknowledges the current interrupt
- irq_out  out  1  interrupt to CPU, level, high while a dispatched interrupt is unacknowledged
- irq_id  out  IDW  ID of the dispatched source; valid while irq_out = 1
- pending  out  NUM_IRQ  latched pending bits, for the status register
- ack_err  out  1  one-cycle pulse: ack received while irq_out = 0

## Operation
- Edge capture:
  - irq_q is irq_in registered.
  - pending[i] is set on any clock where irq_in[i] & ~irq_q[i].
  - Capture is independent of mask and glob_en: masked sources still latch pending.
- pending[i] is cleared only by an accepted ack with irq_id == i.
  - If an ack for source i and a new rising edge on i fall in the same cycle, pending[i] stays 1 (the set wins).
- Eligible vector: elig = pending & mask.
- FSM states:
  - IDLE: go to ARB when glob_en = 1 and elig != 0.
  - ARB:
    - If glob_en = 0 or elig = 0 (changed since IDLE), go to IDLE.
    - Otherwise scan slots 0..NUM_IRQ-1 and take the first slot k with elig[prio_table slot k] = 1.
    - Register that ID into irq_id, set irq_out, go to ACTIVE.
    - If no listed source is eligible, go to IDLE. Sources absent from the table are never dispatched.
    - Duplicate IDs in the table: the lowest slot wins; later duplicates are harmless.
    - Slot IDs >= NUM_IRQ are ignored.
  - ACTIVE:
    - irq_out = 1 and irq_id held stable.
    - On ack: clear pending[irq_id], set irq_out = 0, go to IDLE.
    - No preemption. Changes to mask, prio_table or glob_en do not affect the active interrupt.
- ack in IDLE or ARB: ack_err pulses for one cycle; no other effect.
- Reset values: state = IDLE, irq_q = 0, pending = 0, irq_out = 0, irq_id = 0, ack_err = 0.
  - Reset mid-ACTIVE drops irq_out immediately and loses all pending bits.
- irq_in asserted across reset release: irq_q resets to 0, so an input high at the first clock after reset is captured as an edge.

## Timing
- Rising edge sampled at clock edge k:
  - pending set after edge k;
  - IDLE→ARB at edge k+1;
  - irq_out = 1 and irq_id valid after edge k+2.
- Dispatch latency: 3 edges from sampling to irq_out.
- ack sampled at edge m:
  - irq_out = 0 and pending bit cleared after edge m.
  - If further eligible sources remain, the next dispatch has irq_out = 1 after edge m+2.
  - irq_out is low for at least 2 cycles between consecutive dispatches.
- ack_err asserts the cycle after the offending ack and lasts exactly 1 cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Priority order:
  - Stimulus: mask = 8'h1A, prio_table = 24'd92 (slot0 = 4, slot1 = 3, slot2 = 1), glob_en = 1; irq_in = 8'h1A for one cycle then 0.
  - Required: irq_out rises 3 cycles later with irq_id = 4.
  - Acks then give irq_id 3, then 1. After the third ack: irq_out = 0 and pending = 0.
- Masking:
  - Stimulus: mask = 8'h02, prio_table = 24'd92, irq_in pulse = 8'h18.
  - Required: pending = 8'h18 and irq_out stays 0.
  - Then set mask = 8'h1A: irq_id = 4 dispatched within 3 cycles.
- Global enable:
  - Stimulus: glob_en = 0 with source 1 pending and unmasked.
  - Required: no dispatch.
  - Then set glob_en = 1: irq_out = 1, irq_id = 1 after 2 edges.
- Stray ack: ack pulse in IDLE gives a 1-cycle ack_err pulse; pending and irq_out are unchanged.
- Ack/edge collision: with irq_id = 3 active, pulse ack and a new rising edge on irq_in[3] in the same cycle. Required: pending[3] remains 1 and source 3 is re-dispatched.
- Reset mid-ACTIVE: drop aresetn while irq_out = 1. Required: irq_out = 0, pending = 0, irq_id = 0 immediately, without waiting for a clock.
